// File: rtl/spi_pnb_pkg.sv
// Shared types, constants and the serial CRC-8 step for the SPI-to-PNB link.
package spi_pnb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_CHECK,
      ST_WAIT_CS
   } state_t;

   localparam logic [7:0] CRC_POLY = 8'h07;

   // Bit positions inside the status byte that is returned on sdo
   localparam int STS_FIFO_FULL = 7;
   localparam int STS_CRC_ERR   = 6;
   localparam int STS_SYNC_ERR  = 5;
   localparam int STS_OVERFLOW  = 4;
   localparam int STS_SEQ_SKIP  = 3;
   localparam int STS_SHORT     = 2;

   // One MSB-first CRC-8 shift step: feedback is the outgoing MSB xor the new bit
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic data_bit);
      logic fb;
      fb = crc[7] ^ data_bit;
      return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/spi_pnb_fifo.sv
// Show-ahead payload FIFO with full/empty flags; a push into a full FIFO is
// honoured when a pop happens on the same edge.
module spi_pnb_fifo
   import spi_pnb_pkg::*;
#(
   parameter int WIDTH = 41,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer bookkeeping; the extra MSB tells full apart from empty
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset because head is masked while empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/spi_pnb_frame_link.sv
// SPI receive link: deserialises sync|seq|payload|crc frames on sck, checks
// them, queues good payloads and returns a status byte at the start of each frame.
module spi_pnb_frame_link
   import spi_pnb_pkg::*;
#(
   parameter int                PAYLOAD_W = 41,
   parameter int                SYNC_W    = 8,
   parameter logic [SYNC_W-1:0] SYNC      = 8'hA5,
   parameter int                SEQ_W     = 4,
   parameter int                DEPTH     = 4,
   parameter int                ERR_W     = 8
) (
   input  logic                 sck,
   input  logic                 rstn,
   input  logic                 cs,
   input  logic                 sdi,
   input  logic                 prdy,
   output logic                 sdo,
   output logic [PAYLOAD_W-1:0] payload,
   output logic                 pvld,
   output logic [ERR_W-1:0]     err_cnt,
   output logic                 frame_err
);

   localparam int FRAME_W = SYNC_W + SEQ_W + PAYLOAD_W + 8;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam int CRC_HI  = SYNC_W + SEQ_W + PAYLOAD_W;

   state_t               state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [CNT_W-1:0]     next_cnt;
   logic [FRAME_W-1:0]   frame_sr;
   logic [7:0]           crc;
   logic [7:0]           sts_sr;
   logic [7:0]           status_byte;
   logic                 last_crc_err;
   logic                 last_sync_err;
   logic                 overflow_sticky;
   logic                 seq_skip;
   logic                 last_short;
   logic                 seq_valid;
   logic [SEQ_W-1:0]     last_seq;

   logic [SYNC_W-1:0]    rx_sync;
   logic [SEQ_W-1:0]     rx_seq;
   logic [PAYLOAD_W-1:0] rx_payload;
   logic [7:0]           rx_crc;
   logic                 sync_bad;
   logic                 crc_bad;
   logic                 frame_good;
   logic                 seq_mismatch;
   logic                 overflow;
   logic                 accept;

   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;

   // The CRC covers only the bits between the sync field and the CRC field
   function automatic logic in_crc_span(input logic [CNT_W-1:0] k);
      return (int'(k) > SYNC_W) && (int'(k) <= CRC_HI);
   endfunction

   assign next_cnt     = bit_cnt + CNT_W'(1);
   assign rx_sync      = frame_sr[FRAME_W-1 -: SYNC_W];
   assign rx_seq       = frame_sr[PAYLOAD_W+8 +: SEQ_W];
   assign rx_payload   = frame_sr[8 +: PAYLOAD_W];
   assign rx_crc       = frame_sr[7:0];
   assign sync_bad     = (rx_sync != SYNC);
   assign crc_bad      = (rx_crc != crc);
   assign frame_good   = !sync_bad && !crc_bad;
   assign seq_mismatch = seq_valid && (rx_seq != last_seq + SEQ_W'(1));
   assign fifo_pop     = pvld && prdy;
   assign overflow     = frame_good && fifo_full && !fifo_pop;
   assign accept       = frame_good && !overflow;
   assign fifo_push    = (state == ST_CHECK) && accept;
   assign pvld         = !fifo_empty;

   // Snapshot of the status fields as they stand when a frame begins
   always_comb begin
      status_byte                = '0;
      status_byte[STS_FIFO_FULL] = fifo_full;
      status_byte[STS_CRC_ERR]   = last_crc_err;
      status_byte[STS_SYNC_ERR]  = last_sync_err;
      status_byte[STS_OVERFLOW]  = overflow_sticky;
      status_byte[STS_SEQ_SKIP]  = seq_skip;
      status_byte[STS_SHORT]     = last_short;
   end

   // Frame FSM: receive, evaluate, wait for cs release, with registered status/sdo/error outputs
   always_ff @(posedge sck) begin
      if (!rstn) begin
         state           <= ST_IDLE;
         bit_cnt         <= '0;
         frame_sr        <= '0;
         crc             <= '0;
         sts_sr          <= '0;
         sdo             <= 1'b0;
         err_cnt         <= '0;
         frame_err       <= 1'b0;
         last_crc_err    <= 1'b0;
         last_sync_err   <= 1'b0;
         overflow_sticky <= 1'b0;
         seq_skip        <= 1'b0;
         last_short      <= 1'b0;
         seq_valid       <= 1'b0;
         last_seq        <= '0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               sdo <= 1'b0;
               if (!cs) begin
                  state           <= ST_RECV;
                  bit_cnt         <= CNT_W'(1);
                  frame_sr        <= {frame_sr[FRAME_W-2:0], sdi};
                  crc             <= in_crc_span(CNT_W'(1)) ? crc8_step(8'h00, sdi) : 8'h00;
                  sdo             <= status_byte[7];
                  sts_sr          <= {status_byte[6:0], 1'b0};
                  overflow_sticky <= 1'b0;
               end
            end
            ST_RECV: begin
               if (cs) begin
                  state         <= ST_IDLE;
                  sdo           <= 1'b0;
                  frame_err     <= 1'b0 | 1'b1;
                  last_short    <= 1'b1;
                  last_crc_err  <= 1'b0;
                  last_sync_err <= 1'b0;
                  seq_skip      <= 1'b0;
                  if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
               end else begin
                  frame_sr <= {frame_sr[FRAME_W-2:0], sdi};
                  bit_cnt  <= next_cnt;
                  if (in_crc_span(next_cnt)) crc <= crc8_step(crc, sdi);
                  if (int'(next_cnt) <= 8) begin
                     sdo    <= sts_sr[7];
                     sts_sr <= {sts_sr[6:0], 1'b0};
                  end else begin
                     sdo <= 1'b0;
                  end
                  if (int'(next_cnt) == FRAME_W) state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               state         <= ST_WAIT_CS;
               sdo           <= 1'b0;
               last_crc_err  <= crc_bad;
               last_sync_err <= sync_bad;
               last_short    <= 1'b0;
               seq_skip      <= frame_good && seq_mismatch;
               if (overflow) overflow_sticky <= 1'b1;
               if (accept) begin
                  last_seq  <= rx_seq;
                  seq_valid <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
                  if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
               end
            end
            ST_WAIT_CS: begin
               sdo <= 1'b0;
               if (cs) state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               sdo   <= 1'b0;
            end
         endcase
      end
   end

   spi_pnb_fifo #(
      .WIDTH (PAYLOAD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (sck),
      .rstn      (rstn),
      .push      (fifo_push),
      .push_data (rx_payload),
      .pop       (fifo_pop),
      .head      (payload),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_spi_pnb_frame_link.sv
// Self-checking bench for spi_pnb_frame_link: directed scenarios plus a
// randomized phase, all checked against a frame-level reference model.
module tb_spi_pnb_frame_link;

   localparam int PAYLOAD_W = 41;
   localparam int DEPTH     = 4;
   localparam int FRAME_W   = 61;

   localparam int EV_NONE  = 0;
   localparam int EV_START = 1;
   localparam int EV_CHECK = 2;
   localparam int EV_SHORT = 3;
   localparam int EV_RESET = 4;

   logic                 sck = 1'b0;
   logic                 rstn;
   logic                 cs;
   logic                 sdi;
   logic                 prdy;
   logic                 sdo;
   logic [PAYLOAD_W-1:0] payload;
   logic                 pvld;
   logic [7:0]           err_cnt;
   logic                 frame_err;

   int checks = 0;
   int errors = 0;

   // Reference model state, kept at the level of whole frames and a payload queue
   logic [PAYLOAD_W-1:0] exp_q[$];
   int                   m_err;
   bit                   m_crc_err, m_sync_err, m_ovf, m_skip, m_short;
   bit                   m_seq_valid;
   logic [3:0]           m_last_seq;
   logic [7:0]           exp_status;
   bit                   rand_prdy;

   logic [7:0]           cur_sync;
   logic [3:0]           cur_seq;
   logic [PAYLOAD_W-1:0] cur_payload;
   bit                   cur_crc_good;

   spi_pnb_frame_link dut (
      .sck       (sck),
      .rstn      (rstn),
      .cs        (cs),
      .sdi       (sdi),
      .prdy      (prdy),
      .sdo       (sdo),
      .payload   (payload),
      .pvld      (pvld),
      .err_cnt   (err_cnt),
      .frame_err (frame_err)
   );

   // Free-running link clock
   always #5 sck = ~sck;

   // Safety net so the run always ends even if something stalls
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // CRC-8 (poly 0x07) as the remainder of msg * x^8 divided by x^8+x^2+x+1
   function automatic logic [7:0] ref_crc(input logic [44:0] msg);
      logic [52:0] r;
      r = {msg, 8'h00};
      for (int i = 52; i >= 8; i--)
         if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
      return r[7:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one sck edge, updating the model for the frame event at that edge, then check outputs
   task automatic applyStimulus(input int ev);
      bit do_pop, rej, good, ovf;
      if (rand_prdy) prdy = 1'($urandom_range(0, 1));
      do_pop = (exp_q.size() > 0) && (prdy === 1'b1);
      rej    = 0;
      good   = 0;
      ovf    = 0;
      case (ev)
         EV_RESET: begin
            exp_q.delete();
            m_err = 0;
            {m_crc_err, m_sync_err, m_ovf, m_skip, m_short, m_seq_valid} = '0;
            do_pop = 0;
         end
         EV_START: begin
            exp_status = {exp_q.size() == DEPTH, m_crc_err, m_sync_err, m_ovf, m_skip, m_short, 2'b00};
            m_ovf = 0;
         end
         EV_SHORT: begin
            rej = 1;
            m_short = 1;
            m_crc_err = 0;
            m_sync_err = 0;
            m_skip = 0;
         end
         EV_CHECK: begin
            good       = (cur_sync == 8'hA5) && cur_crc_good;
            ovf        = good && (exp_q.size() == DEPTH) && !do_pop;
            m_skip     = good && m_seq_valid && (cur_seq != 4'(m_last_seq + 4'd1));
            m_crc_err  = !cur_crc_good;
            m_sync_err = (cur_sync != 8'hA5);
            m_short    = 0;
            if (ovf) m_ovf = 1;
            rej = !good || ovf;
         end
         default: ;
      endcase
      if (do_pop) void'(exp_q.pop_front());
      if (good && !ovf) begin
         exp_q.push_back(cur_payload);
         m_last_seq  = cur_seq;
         m_seq_valid = 1;
      end
      if (rej && m_err < 255) m_err++;
      @(posedge sck);
      #1;
      checkOutput("pvld", pvld, exp_q.size() > 0);
      checkOutput("payload", payload, (exp_q.size() > 0) ? exp_q[0] : '0);
      checkOutput("err_cnt", err_cnt, m_err);
      checkOutput("frame_err", frame_err, rej);
      if (ev == EV_CHECK || ev == EV_SHORT || ev == EV_RESET) checkOutput("sdo_quiet", sdo, 0);
   endtask

   // Send nbits of a frame MSB first, collect the status byte, then release cs
   task automatic send_frame(input logic [7:0] sy, input logic [3:0] sq, input logic [PAYLOAD_W-1:0] pl,
                             input bit bad_crc, input int nbits, output logic [7:0] st);
      logic [FRAME_W-1:0] f;
      logic [7:0]         c;
      c = ref_crc({sq, pl});
      if (bad_crc) c = c ^ 8'h01;
      f = {sy, sq, pl, c};
      cur_sync = sy;
      cur_seq = sq;
      cur_payload = pl;
      cur_crc_good = !bad_crc;
      st = '0;
      for (int i = 1; i <= nbits; i++) begin
         cs  = 1'b0;
         sdi = f[FRAME_W-i];
         applyStimulus(i == 1 ? EV_START : EV_NONE);
         if (i <= 8) st[8-i] = sdo;
      end
      cs  = 1'b1;
      sdi = 1'b0;
      applyStimulus(nbits == FRAME_W ? EV_CHECK : EV_SHORT);
      if (nbits == FRAME_W) applyStimulus(EV_NONE);
      applyStimulus(EV_NONE);
      if (nbits >= 8) checkOutput("status", st, exp_status);
   endtask

   logic [PAYLOAD_W-1:0] pl_arr [1:5];
   logic [7:0]           st;
   logic [63:0]          rnd;

   // Directed scenarios followed by randomized traffic, saturation and mid-frame reset
   initial begin
      rstn = 1'b0;
      cs = 1'b1;
      sdi = 1'b0;
      prdy = 1'b1;
      rand_prdy = 0;
      applyStimulus(EV_RESET);
      applyStimulus(EV_RESET);
      checkOutput("reset_sdo", sdo, 0);
      rstn = 1'b1;
      applyStimulus(EV_NONE);

      $display("[TB] good frame");
      send_frame(8'hA5, 4'd0, 41'h1_2345_6789A, 0, FRAME_W, st);
      checkOutput("good_status", st, 8'h00);
      checkOutput("good_err", err_cnt, 0);

      $display("[TB] corrupt crc");
      send_frame(8'hA5, 4'd1, 41'h0_0BAD_C0DE1, 1, FRAME_W, st);
      checkOutput("crc_err_cnt", err_cnt, 1);

      $display("[TB] fill fifo with prdy low");
      prdy = 1'b0;
      for (int s = 1; s <= 5; s++) begin
         rnd = {$urandom, $urandom};
         pl_arr[s] = rnd[PAYLOAD_W-1:0];
         send_frame(8'hA5, 4'(s), pl_arr[s], 0, FRAME_W, st);
         if (s == 1) checkOutput("status_after_crc", st, 8'b0100_0000);
      end
      checkOutput("ovf_err_cnt", err_cnt, 2);
      send_frame(8'h00, 4'd6, 41'h0, 0, FRAME_W, st);
      checkOutput("status_after_ovf", st, 8'b1001_0000);

      $display("[TB] drain");
      prdy = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         checkOutput("drain", payload, pl_arr[k]);
         applyStimulus(EV_NONE);
      end
      checkOutput("drained_pvld", pvld, 0);

      $display("[TB] short frame");
      send_frame(8'hA5, 4'd5, 41'h1_5555_0000F, 0, 30, st);
      checkOutput("short_err_cnt", err_cnt, 4);
      send_frame(8'hA5, 4'd5, 41'h0_AAAA_1234F, 0, FRAME_W, st);
      checkOutput("status_after_short", st, 8'b0000_0100);
      checkOutput("after_short_err_cnt", err_cnt, 4);

      $display("[TB] sequence skip");
      send_frame(8'hA5, 4'd3, 41'h0_0000_00333, 0, FRAME_W, st);
      send_frame(8'hA5, 4'd5, 41'h0_0000_00555, 0, FRAME_W, st);
      send_frame(8'hA5, 4'd6, 41'h0_0000_00666, 0, FRAME_W, st);
      checkOutput("status_seq_skip", st, 8'b0000_1000);

      $display("[TB] randomized traffic");
      rand_prdy = 1;
      for (int n = 0; n < 60; n++) begin
         logic [7:0] sy;
         int         nb;
         rnd = {$urandom, $urandom};
         sy  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hA5;
         nb  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, FRAME_W - 1)) : FRAME_W;
         send_frame(sy, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(m_last_seq + 4'd1),
                    rnd[PAYLOAD_W-1:0], $urandom_range(0, 5) == 0, nb, st);
         repeat ($urandom_range(0, 2)) applyStimulus(EV_NONE);
      end
      rand_prdy = 0;
      prdy = 1'b1;

      $display("[TB] error counter saturation");
      for (int n = 0; n < 300; n++)
         send_frame(8'h5A, 4'd0, 41'h0_1111_22223, 0, FRAME_W, st);
      checkOutput("err_saturated", err_cnt, 8'hFF);

      $display("[TB] reset mid-frame");
      send_frame(8'hA5, 4'(m_last_seq + 4'd1), 41'h0_7777_88889, 0, FRAME_W, st);
      cur_sync = 8'hA5;
      for (int i = 1; i <= 20; i++) begin
         cs  = 1'b0;
         sdi = i[0];
         applyStimulus(i == 1 ? EV_START : EV_NONE);
      end
      rstn = 1'b0;
      cs = 1'b1;
      applyStimulus(EV_RESET);
      checkOutput("rst_err_cnt", err_cnt, 0);
      checkOutput("rst_pvld", pvld, 0);
      checkOutput("rst_payload", payload, 0);
      rstn = 1'b1;
      applyStimulus(EV_NONE);
      send_frame(8'hA5, 4'd9, 41'h1_2345_6789A, 0, FRAME_W, st);
      checkOutput("post_rst_status", st, 8'h00);
      checkOutput("post_rst_err", err_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
